// File: rtl/ai_paddle_ctrl.sv
// Computer-controlled paddle opponent. It watches the ball and paddle positions
// and drives the active-low up/down command pair of the right-hand paddle.
// While the ball approaches, the paddle tracks it after a reaction delay and
// ignores small errors inside a deadband. While the ball moves away, the paddle
// returns to the centre of the field.
module ai_paddle_ctrl #(
  parameter int TICK_W      = 18,
  parameter int REACT_TICKS = 8,
  parameter int DEADBAND    = 4,
  parameter int CENTER_Y    = 240,
  parameter int Y_MAX       = 480,
  parameter int DATA_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] ball_y,
  input  logic              ball_toward,
  input  logic [DATA_W-1:0] paddle_y,
  output logic              mv_up_n,
  output logic              mv_down_n,
  output logic              busy
);

  localparam int CNT_W = (REACT_TICKS > 1) ? $clog2(REACT_TICKS) : 1;
  localparam logic [DATA_W-1:0]        YMAX_V   = DATA_W'(Y_MAX);
  localparam logic [DATA_W-1:0]        CENTER_V = DATA_W'(CENTER_Y);
  localparam logic signed [DATA_W:0]   DB       = (DATA_W+1)'(DEADBAND);
  localparam logic [CNT_W-1:0]         REACT_LAST = CNT_W'(REACT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REACT    = 2'd1,
    TRACK    = 2'd2,
    RECENTRE = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic [TICK_W-1:0]        tick_cnt;
  logic                     tick;
  logic [CNT_W-1:0]         react_cnt, react_nxt;
  logic                     up_nxt, down_nxt;
  logic [DATA_W-1:0]        target;
  logic signed [DATA_W:0]   diff;
  logic                     in_band;
  logic [1:0]               cmd;

  // Clamp the tracking target so the paddle is never asked to go below its travel.
  function automatic logic [DATA_W-1:0] clamp_y(input logic [DATA_W-1:0] y);
    if (y > YMAX_V) return YMAX_V;
    return y;
  endfunction

  // Map a signed position error to {up_n, down_n}; the travel limits block
  // commands that would push the paddle off either end.
  function automatic logic [1:0] move_cmd(input logic signed [DATA_W:0] d,
                                          input logic [DATA_W-1:0]      py);
    logic [1:0] c;
    c = 2'b11;
    if ((d > DB) && (py < YMAX_V))
      c = 2'b10;
    else if ((d < -DB) && (py != '0))
      c = 2'b01;
    return c;
  endfunction

  // Free-running decision-rate divider; keeps counting even while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick_cnt + TICK_W'(1);
  end

  assign tick = &tick_cnt;

  assign target  = (state == TRACK) ? clamp_y(ball_y) : CENTER_V;
  assign diff    = $signed({1'b0, target}) - $signed({1'b0, paddle_y});
  assign in_band = (diff <= DB) && (diff >= -DB);
  assign cmd     = move_cmd(diff, paddle_y);

  // Next-state, reaction counter and command decision; disable overrides the tick.
  always_comb begin
    state_nxt = state;
    react_nxt = react_cnt;
    up_nxt    = mv_up_n;
    down_nxt  = mv_down_n;
    if (!enable) begin
      state_nxt = IDLE;
      react_nxt = '0;
      up_nxt    = 1'b1;
      down_nxt  = 1'b1;
    end else if (tick) begin
      case (state)
        IDLE: begin
          up_nxt   = 1'b1;
          down_nxt = 1'b1;
          if (ball_toward) begin
            state_nxt = REACT;
            react_nxt = '0;
          end else begin
            state_nxt = RECENTRE;
          end
        end
        REACT: begin
          up_nxt   = 1'b1;
          down_nxt = 1'b1;
          if (!ball_toward)
            state_nxt = RECENTRE;
          else if (react_cnt == REACT_LAST)
            state_nxt = TRACK;
          else
            react_nxt = react_cnt + CNT_W'(1);
        end
        TRACK: begin
          up_nxt   = cmd[1];
          down_nxt = cmd[0];
          if (!ball_toward) state_nxt = RECENTRE;
        end
        RECENTRE: begin
          up_nxt   = cmd[1];
          down_nxt = cmd[0];
          if (ball_toward) begin
            state_nxt = REACT;
            react_nxt = '0;
          end else if (in_band) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          up_nxt    = 1'b1;
          down_nxt  = 1'b1;
        end
      endcase
    end
  end

  // State, reaction counter and registered commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      react_cnt <= '0;
      mv_up_n   <= 1'b1;
      mv_down_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      react_cnt <= react_nxt;
      mv_up_n   <= up_nxt;
      mv_down_n <= down_nxt;
    end
  end

  assign busy = (state == TRACK) || (state == RECENTRE);

  // The paddle must never be told to move both ways at once.
  assert property (@(posedge clk) disable iff (!rst_n) (mv_up_n || mv_down_n));

endmodule

// File: tb/tb_ai_paddle_ctrl.sv
// Self-checking bench for ai_paddle_ctrl: directed scenarios followed by a
// randomized run, all compared against a tick-level behavioural model.
module tb_ai_paddle_ctrl;

  localparam int TW   = 2;
  localparam int RT   = 2;
  localparam int DB   = 4;
  localparam int CY   = 240;
  localparam int YMAX = 480;

  localparam int M_IDLE = 0, M_REACT = 1, M_TRACK = 2, M_RECENTRE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [9:0] ball_y;
  logic       ball_toward;
  logic [9:0] paddle_y;
  logic       mv_up_n, mv_down_n, busy;

  int tests = 0;
  int fails = 0;

  // Behavioural model: mode, ticks spent reacting, wanted moves, clock phase.
  int m_mode, m_wait, m_phase;
  bit m_up, m_dn, m_ticked;

  ai_paddle_ctrl #(
    .TICK_W(TW), .REACT_TICKS(RT), .DEADBAND(DB),
    .CENTER_Y(CY), .Y_MAX(YMAX), .DATA_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ball_y(ball_y),
    .ball_toward(ball_toward), .paddle_y(paddle_y),
    .mv_up_n(mv_up_n), .mv_down_n(mv_down_n), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_wait = 0; m_up = 0; m_dn = 0; m_phase = 0; m_ticked = 0;
  endtask

  // One clock edge of the model: decisions are taken once every 2**TW clocks.
  task automatic model_edge();
    bit tk;
    int tgt, d;
    tk       = (m_phase == (1 << TW) - 1);
    m_phase  = (m_phase + 1) % (1 << TW);
    m_ticked = tk;
    if (!enable) begin
      m_mode = M_IDLE; m_wait = 0; m_up = 0; m_dn = 0;
    end else if (tk) begin
      if (m_mode == M_TRACK || m_mode == M_RECENTRE) begin
        if (m_mode == M_TRACK) tgt = (int'(ball_y) > YMAX) ? YMAX : int'(ball_y);
        else                   tgt = CY;
        d    = tgt - int'(paddle_y);
        m_dn = (d > DB) && (int'(paddle_y) < YMAX);
        m_up = (d < -DB) && (int'(paddle_y) > 0);
      end else begin
        m_up = 0; m_dn = 0;
      end
      case (m_mode)
        M_IDLE: begin
          if (ball_toward) begin m_mode = M_REACT; m_wait = 0; end
          else m_mode = M_RECENTRE;
        end
        M_REACT: begin
          if (!ball_toward)        m_mode = M_RECENTRE;
          else if (m_wait + 1 >= RT) m_mode = M_TRACK;
          else                     m_wait++;
        end
        M_TRACK: if (!ball_toward) m_mode = M_RECENTRE;
        default: begin
          if (ball_toward) begin m_mode = M_REACT; m_wait = 0; end
          else if ((CY - int'(paddle_y) <= DB) && (int'(paddle_y) - CY <= DB)) m_mode = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("up_n", mv_up_n, !m_up);
    check("down_n", mv_down_n, !m_dn);
    check("busy", busy, (m_mode == M_TRACK) || (m_mode == M_RECENTRE));
    check("exclusive", mv_up_n | mv_down_n, 1'b1);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run_to_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle();
      seen = m_ticked;
    end
    if (!seen) begin
      tests++;
      fails++;
      $error("FAIL tick_wait observed=none expected=tick within 8 clocks");
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; ball_y = '0; ball_toward = 1'b0; paddle_y = 10'd240;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_up_n", mv_up_n, 1'b1);
    check("rst_down_n", mv_down_n, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Approach: two reaction ticks with commands released, then track downward.
    enable = 1'b1; ball_toward = 1'b1; ball_y = 10'd400; paddle_y = 10'd240;
    run_to_tick();
    check("t2_idle_dn", mv_down_n, 1'b1);
    run_to_tick();
    check("t2_react1_dn", mv_down_n, 1'b1);
    run_to_tick();
    check("t2_react2_dn", mv_down_n, 1'b1);
    run_to_tick();
    check("t2_track_dn", mv_down_n, 1'b0);
    check("t2_track_up", mv_up_n, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t2_hold_dn", mv_down_n, 1'b0);
    end

    // Deadband then a large upward error.
    ball_y = 10'd243;
    run_to_tick();
    check("t3_band_dn", mv_down_n, 1'b1);
    check("t3_band_up", mv_up_n, 1'b1);
    ball_y = 10'd10;
    run_to_tick();
    check("t3_up", mv_up_n, 1'b0);

    // Travel limits and target clamp.
    ball_y = 10'd600; paddle_y = 10'd480;
    run_to_tick();
    check("t4_ymax_dn", mv_down_n, 1'b1);
    paddle_y = 10'd478;
    run_to_tick();
    check("t4_clamp_dn", mv_down_n, 1'b1);
    ball_y = 10'd0; paddle_y = 10'd0;
    run_to_tick();
    check("t4_top_up", mv_up_n, 1'b1);

    // Ball leaves: recentre from below centre, then settle into idle.
    ball_toward = 1'b0; ball_y = 10'd300; paddle_y = 10'd100;
    run_to_tick();
    check("t5_recentre_dn", mv_down_n, 1'b0);
    check("t5_busy", busy, 1'b1);
    paddle_y = 10'd238;
    run_to_tick();
    check("t5_idle_dn", mv_down_n, 1'b1);
    check("t5_idle_up", mv_up_n, 1'b1);
    check("t5_idle_busy", busy, 1'b0);

    // Disable between ticks while moving up.
    paddle_y = 10'd400;
    run_to_tick();
    run_to_tick();
    check("t6_up_before", mv_up_n, 1'b0);
    enable = 1'b0;
    cycle();
    check("t6_up_after", mv_up_n, 1'b1);
    check("t6_busy_after", busy, 1'b0);
    enable = 1'b1;

    // Asynchronous reset while tracking downward.
    ball_toward = 1'b1; ball_y = 10'd400; paddle_y = 10'd240;
    for (int i = 0; i < 4; i++) run_to_tick();
    check("t1_dn_before", mv_down_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_up", mv_up_n, 1'b1);
    check("t1_rst_dn", mv_down_n, 1'b1);
    check("t1_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Randomized run.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 39) == 0)     enable = 1'b0;
      else if ($urandom_range(0, 5) == 0) enable = 1'b1;
      if ($urandom_range(0, 11) == 0) ball_toward = ~ball_toward;
      if ($urandom_range(0, 3) == 0)  ball_y = 10'($urandom_range(0, 1023));
      case ($urandom_range(0, 5))
        0:       paddle_y = 10'd0;
        1:       paddle_y = 10'd480;
        2:       paddle_y = 10'($urandom_range(232, 248));
        3:       paddle_y = 10'($urandom_range(481, 1023));
        default: paddle_y = 10'($urandom_range(0, 600));
      endcase
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
